// File: rtl/gat_debug_pkg.sv
// Shared definitions for the debug readout path: sync byte, FSM state type,
// debug word type and frame-length helper.
package gat_debug_pkg;

    localparam logic [7:0] DBG_SYNC_BYTE = 8'hA5;
    // Byte index width; covers the longest frame (15 words -> index 63).
    localparam int DBG_IDX_W = 6;

    typedef enum logic {IDLE, SEND} dbg_tx_state_t;
    typedef logic [31:0] dbg_word_t;

    // Index of the checksum byte, equal to the header+data byte count.
    function automatic logic [DBG_IDX_W-1:0] dbg_frame_len(input int num_words);
        return DBG_IDX_W'(3 + 4 * num_words);
    endfunction

endpackage

// File: rtl/debug_byte_sel.sv
// Combinational byte selector: maps a frame byte index to the header or
// snapshot data byte. The checksum byte is supplied by the caller.
module debug_byte_sel
    import gat_debug_pkg::*;
#(
    parameter int         NUM_WORDS = 3,
    parameter logic [7:0] SYNC_BYTE = DBG_SYNC_BYTE
) (
    input  logic [DBG_IDX_W-1:0]     byte_idx,
    input  logic [7:0]               seq,
    input  logic [NUM_WORDS*32-1:0]  snapshot,
    output logic [7:0]               byte_o
);

    localparam logic [DBG_IDX_W-1:0] FRAME_L  = dbg_frame_len(NUM_WORDS);
    localparam logic [DBG_IDX_W-1:0] IDX_SYNC = DBG_IDX_W'(0);
    localparam logic [DBG_IDX_W-1:0] IDX_SEQ  = DBG_IDX_W'(1);
    localparam logic [DBG_IDX_W-1:0] IDX_NW   = DBG_IDX_W'(2);
    localparam logic [3:0]           NW       = 4'(NUM_WORDS);

    logic [DBG_IDX_W-1:0] d_idx;
    dbg_word_t            word_sel;

    // Data byte offset: upper bits pick the word, low two bits the byte (MSB first).
    assign d_idx = byte_idx - DBG_IDX_W'(3);

    always_comb begin
        word_sel = '0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            if (d_idx[DBG_IDX_W-1:2] == 4'(w)) begin
                word_sel = snapshot[w*32 +: 32];
            end
        end

        byte_o = '0;
        if (byte_idx == IDX_SYNC) begin
            byte_o = SYNC_BYTE;
        end else if (byte_idx == IDX_SEQ) begin
            byte_o = seq;
        end else if (byte_idx == IDX_NW) begin
            byte_o = {4'h0, NW};
        end else if (byte_idx < FRAME_L) begin
            case (d_idx[1:0])
                2'd0:    byte_o = word_sel[31:24];
                2'd1:    byte_o = word_sel[23:16];
                2'd2:    byte_o = word_sel[15:8];
                default: byte_o = word_sel[7:0];
            endcase
        end
    end

endmodule

// File: rtl/debug_frame_tx.sv
// Snapshots the debug probe words on request and streams them as a framed,
// XOR-checksummed byte sequence over a valid/ready byte interface.
module debug_frame_tx
    import gat_debug_pkg::*;
#(
    parameter int         NUM_WORDS = 3,
    parameter int         WORD_W    = 32,
    parameter logic [7:0] SYNC_BYTE = DBG_SYNC_BYTE,
    parameter int         CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cap_req_i,
    input  logic [NUM_WORDS*WORD_W-1:0] dbg_words_i,
    output logic [7:0]                  tx_data_o,
    output logic                        tx_vld_o,
    input  logic                        tx_rdy_i,
    output logic                        busy_o,
    output logic [CNT_W-1:0]            frame_cnt_o,
    output logic [CNT_W-1:0]            drop_cnt_o
);

    // Handshake: a byte moves when tx_vld_o & tx_rdy_i at a rising edge; while
    // tx_vld_o is high, tx_data_o and tx_vld_o hold until that happens (reset excepted).

    localparam logic [DBG_IDX_W-1:0] CKSUM_IDX = dbg_frame_len(NUM_WORDS);
    localparam logic [DBG_IDX_W-1:0] IDX_ZERO  = DBG_IDX_W'(0);

    dbg_tx_state_t                 state, state_nxt;
    logic [DBG_IDX_W-1:0]          byte_idx, idx_nxt, idx_inc;
    logic [NUM_WORDS*WORD_W-1:0]   snapshot, snap_nxt;
    logic [7:0]                    seq, seq_nxt;
    logic [7:0]                    cksum, cksum_nxt;
    logic [7:0]                    data_nxt, sel_byte;
    logic                          vld_nxt, busy_nxt, accept;
    logic [CNT_W-1:0]              frame_nxt, drop_nxt;

    assign accept  = tx_vld_o & tx_rdy_i;
    assign idx_inc = byte_idx + DBG_IDX_W'(1);

    debug_byte_sel #(
        .NUM_WORDS (NUM_WORDS),
        .SYNC_BYTE (SYNC_BYTE)
    ) u_byte_sel (
        .byte_idx (idx_inc),
        .seq      (seq),
        .snapshot (snapshot),
        .byte_o   (sel_byte)
    );

    always_comb begin
        state_nxt = state;
        idx_nxt   = byte_idx;
        snap_nxt  = snapshot;
        seq_nxt   = seq;
        cksum_nxt = cksum;
        data_nxt  = tx_data_o;
        vld_nxt   = tx_vld_o;
        busy_nxt  = busy_o;
        frame_nxt = frame_cnt_o;
        drop_nxt  = drop_cnt_o;

        case (state)
            IDLE: begin
                if (cap_req_i) begin
                    state_nxt = SEND;
                    snap_nxt  = dbg_words_i;
                    seq_nxt   = frame_cnt_o[7:0];
                    idx_nxt   = '0;
                    cksum_nxt = '0;
                    data_nxt  = SYNC_BYTE;
                    vld_nxt   = 1'b1;
                    busy_nxt  = 1'b1;
                end
            end
            SEND: begin
                if (accept) begin
                    if (byte_idx == CKSUM_IDX) begin
                        state_nxt = IDLE;
                        data_nxt  = '0;
                        vld_nxt   = 1'b0;
                        busy_nxt  = 1'b0;
                        frame_nxt = frame_cnt_o + 1'b1;
                    end else begin
                        idx_nxt = idx_inc;
                        // SYNC is excluded; every later header/data byte folds in.
                        if (byte_idx != IDX_ZERO) begin
                            cksum_nxt = cksum ^ tx_data_o;
                        end
                        data_nxt = (idx_inc == CKSUM_IDX) ? cksum_nxt : sel_byte;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (busy_o && cap_req_i && (drop_cnt_o != '1)) begin
            drop_nxt = drop_cnt_o + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            byte_idx    <= '0;
            snapshot    <= '0;
            seq         <= '0;
            cksum       <= '0;
            tx_data_o   <= '0;
            tx_vld_o    <= 1'b0;
            busy_o      <= 1'b0;
            frame_cnt_o <= '0;
            drop_cnt_o  <= '0;
        end else begin
            state       <= state_nxt;
            byte_idx    <= idx_nxt;
            snapshot    <= snap_nxt;
            seq         <= seq_nxt;
            cksum       <= cksum_nxt;
            tx_data_o   <= data_nxt;
            tx_vld_o    <= vld_nxt;
            busy_o      <= busy_nxt;
            frame_cnt_o <= frame_nxt;
            drop_cnt_o  <= drop_nxt;
        end
    end

endmodule

// File: tb/tb_debug_frame_tx.sv
// Bench for debug_frame_tx: model frames queued at request time, popped and
// compared as bytes are accepted on the output handshake.
module tb_debug_frame_tx;

    localparam int NW = 3;
    localparam int SW = NW * 32;
    localparam int FRAME_BYTES = 3 + 4 * NW + 1;
    localparam logic [SW-1:0] W_BASIC = {32'h0000_00FF, 32'h00FF_FFFF, 32'h0000_000C};

    logic           clk = 1'b0;
    logic           rst;
    logic           cap_req_i;
    logic [SW-1:0]  dbg_words_i;
    logic [7:0]     tx_data_o;
    logic           tx_vld_o;
    logic           tx_rdy_i;
    logic           busy_o;
    logic [15:0]    frame_cnt_o;
    logic [15:0]    drop_cnt_o;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  exp_q[$];
    int          acc_cnt = 0;
    bit          rdy_random = 1'b0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;
    logic [15:0] model_frames;
    logic [15:0] model_drops;
    int          base;
    logic [SW-1:0] w_tmp;

    debug_frame_tx #(.NUM_WORDS(NW)) dut (
        .clk         (clk),
        .rst         (rst),
        .cap_req_i   (cap_req_i),
        .dbg_words_i (dbg_words_i),
        .tx_data_o   (tx_data_o),
        .tx_vld_o    (tx_vld_o),
        .tx_rdy_i    (tx_rdy_i),
        .busy_o      (busy_o),
        .frame_cnt_o (frame_cnt_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_model(input logic [SW-1:0] w, input logic [7:0] seq);
        logic [7:0]    b;
        logic [7:0]    ck;
        logic [SW-1:0] sh;
        exp_q.push_back(8'hA5);
        exp_q.push_back(seq);
        exp_q.push_back(8'(NW));
        ck = seq ^ 8'(NW);
        for (int i = 0; i < NW; i++) begin
            for (int j = 0; j < 4; j++) begin
                sh = w >> (i * 32 + 24 - 8 * j);
                b  = sh[7:0];
                exp_q.push_back(b);
                ck = ck ^ b;
            end
        end
        exp_q.push_back(ck);
    endtask

    task automatic push_basic_const();
        logic [7:0] tbl [16] = '{8'hA5, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h00,
                                 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h0F};
        for (int i = 0; i < 16; i++) exp_q.push_back(tbl[i]);
    endtask

    task automatic drive_req(input logic [SW-1:0] w);
        dbg_words_i = w;
        cap_req_i   = 1'b1;
        tick();
        cap_req_i   = 1'b0;
    endtask

    task automatic wait_accepted(input int target, input int budget);
        int n;
        n = 0;
        while (acc_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check("wait_bytes", 32'(acc_cnt >= target), 32'd1);
    endtask

    task automatic model_drop();
        if (model_drops != 16'hFFFF) model_drops = model_drops + 16'd1;
    endtask

    // Ready driver: constant high, or a fresh coin flip each cycle.
    initial begin
        tx_rdy_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_rdy_i = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: byte scoreboard plus stall-stability checks.
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_vld", 32'(tx_vld_o), 32'd1);
                check("stall_data", 32'(tx_data_o), 32'(prev_data));
            end
            if (tx_vld_o && tx_rdy_i) begin
                check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check($sformatf("byte%0d", acc_cnt % FRAME_BYTES), 32'(tx_data_o), 32'(e));
                end
                acc_cnt++;
            end
            prev_stall = tx_vld_o && !tx_rdy_i;
            prev_data  = tx_data_o;
        end
    end

    initial begin
        rst = 1'b1;
        cap_req_i = 1'b0;
        dbg_words_i = '0;
        model_frames = '0;
        model_drops = '0;
        repeat (2) tick();
        check("rst_vld", 32'(tx_vld_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_data", 32'(tx_data_o), 32'd0);
        check("rst_frame", 32'(frame_cnt_o), 32'd0);
        check("rst_drop", 32'(drop_cnt_o), 32'd0);
        rst = 1'b0;
        tick();

        // Basic frame against the literal byte table.
        base = acc_cnt;
        push_basic_const();
        drive_req(W_BASIC);
        check("sync_latency_vld", 32'(tx_vld_o), 32'd1);
        check("sync_latency_data", 32'(tx_data_o), 32'hA5);
        check("busy_start", 32'(busy_o), 32'd1);
        wait_accepted(base + FRAME_BYTES, 100);
        model_frames++;
        check("basic_frame_cnt", 32'(frame_cnt_o), 32'(model_frames));
        check("basic_busy_end", 32'(busy_o), 32'd0);
        check("basic_vld_end", 32'(tx_vld_o), 32'd0);

        // Random backpressure.
        rdy_random = 1'b1;
        base = acc_cnt;
        push_model(W_BASIC, model_frames[7:0]);
        drive_req(W_BASIC);
        wait_accepted(base + FRAME_BYTES, 400);
        rdy_random = 1'b0;
        model_frames++;
        tick();
        check("bp_frame_cnt", 32'(frame_cnt_o), 32'(model_frames));

        // Snapshot isolation: inputs scrambled every cycle after the request.
        base = acc_cnt;
        w_tmp = {$urandom, $urandom, $urandom};
        push_model(w_tmp, model_frames[7:0]);
        drive_req(w_tmp);
        for (int n = 0; n < 100 && acc_cnt < base + FRAME_BYTES; n++) begin
            dbg_words_i = {$urandom, $urandom, $urandom};
            tick();
        end
        check("iso_done", 32'(acc_cnt >= base + FRAME_BYTES), 32'd1);
        model_frames++;
        check("iso_frame_cnt", 32'(frame_cnt_o), 32'(model_frames));

        // Drops at byte 5 and on the checksum acceptance cycle, then a restart.
        base = acc_cnt;
        w_tmp = {$urandom, $urandom, $urandom};
        push_model(w_tmp, model_frames[7:0]);
        drive_req(w_tmp);
        wait_accepted(base + 5, 50);
        cap_req_i = 1'b1;
        tick();
        cap_req_i = 1'b0;
        model_drop();
        wait_accepted(base + FRAME_BYTES - 1, 50);
        w_tmp = {$urandom, $urandom, $urandom};
        dbg_words_i = w_tmp;
        cap_req_i = 1'b1;
        push_model(w_tmp, 8'(model_frames + 16'd1));
        tick();
        model_drop();
        model_frames++;
        check("drop_busy_end", 32'(busy_o), 32'd0);
        check("drop_frame_cnt", 32'(frame_cnt_o), 32'(model_frames));
        check("drop_cnt", 32'(drop_cnt_o), 32'(model_drops));
        tick();
        cap_req_i = 1'b0;
        check("restart_vld", 32'(tx_vld_o), 32'd1);
        check("restart_busy", 32'(busy_o), 32'd1);
        wait_accepted(base + 2 * FRAME_BYTES, 100);
        model_frames++;
        check("restart_frame_cnt", 32'(frame_cnt_o), 32'(model_frames));

        // Reset mid-frame.
        base = acc_cnt;
        w_tmp = {$urandom, $urandom, $urandom};
        push_model(w_tmp, model_frames[7:0]);
        drive_req(w_tmp);
        wait_accepted(base + 8, 50);
        rst = 1'b1;
        exp_q.delete();
        tick();
        check("midrst_vld", 32'(tx_vld_o), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_frame", 32'(frame_cnt_o), 32'd0);
        check("midrst_drop", 32'(drop_cnt_o), 32'd0);
        rst = 1'b0;
        model_frames = '0;
        model_drops = '0;
        tick();
        base = acc_cnt;
        w_tmp = {$urandom, $urandom, $urandom};
        push_model(w_tmp, 8'h00);
        drive_req(w_tmp);
        wait_accepted(base + FRAME_BYTES, 100);
        model_frames++;
        check("postrst_frame_cnt", 32'(frame_cnt_o), 32'(model_frames));

        // Frame counter wrap.
        force dut.frame_cnt_o = 16'hFFFF;
        tick();
        release dut.frame_cnt_o;
        model_frames = 16'hFFFF;
        tick();
        base = acc_cnt;
        w_tmp = {$urandom, $urandom, $urandom};
        push_model(w_tmp, 8'hFF);
        drive_req(w_tmp);
        wait_accepted(base + FRAME_BYTES, 100);
        model_frames++;
        check("wrap_frame_cnt", 32'(frame_cnt_o), 32'(model_frames));

        // Drop counter saturation.
        force dut.drop_cnt_o = 16'hFFFF;
        tick();
        release dut.drop_cnt_o;
        model_drops = 16'hFFFF;
        tick();
        base = acc_cnt;
        w_tmp = {$urandom, $urandom, $urandom};
        push_model(w_tmp, model_frames[7:0]);
        drive_req(w_tmp);
        wait_accepted(base + 3, 50);
        cap_req_i = 1'b1;
        tick();
        cap_req_i = 1'b0;
        model_drop();
        wait_accepted(base + FRAME_BYTES, 100);
        model_frames++;
        check("sat_drop_cnt", 32'(drop_cnt_o), 32'(model_drops));
        check("sat_frame_cnt", 32'(frame_cnt_o), 32'(model_frames));

        repeat (3) tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
